// File: rtl/priv_ext_csr_requester_if.sv
// Privilege-extension CSR bus: execute-stage request/response plus the broadcast extension bus.
// master = CSR requester, slave = pipeline/extension side driving requests and ack data.
interface priv_ext_csr_requester_if #(
  parameter int NUM_EXT = 2
);
  logic                     req_valid;
  logic                     req_ready;
  logic [11:0]              req_addr;
  logic [1:0]               req_op;
  logic [31:0]              req_wdata;
  logic                     req_write_en;
  logic                     resp_valid;
  logic [31:0]              resp_rdata;
  logic                     resp_invalid;
  logic [11:0]              ext_csr_addr;
  logic                     ext_csr_active;
  logic [31:0]              ext_value_in;
  logic [NUM_EXT-1:0]       ext_ack;
  logic [NUM_EXT-1:0]       ext_invalid_csr;
  logic [32*NUM_EXT-1:0]    ext_value_out;

  modport master (
    input  req_valid, req_addr, req_op, req_wdata, req_write_en,
    input  ext_ack, ext_invalid_csr, ext_value_out,
    output req_ready, resp_valid, resp_rdata, resp_invalid,
    output ext_csr_addr, ext_csr_active, ext_value_in
  );

  modport slave (
    output req_valid, req_addr, req_op, req_wdata, req_write_en,
    output ext_ack, ext_invalid_csr, ext_value_out,
    input  req_ready, resp_valid, resp_rdata, resp_invalid,
    input  ext_csr_addr, ext_csr_active, ext_value_in
  );
endinterface

// File: rtl/priv_ext_csr_requester.sv
// Zicsr read-modify-write initiator over the extension CSR bus; one access in flight at a time.
// Latency: 1 cycle (illegal op), 2 (read), 3 (write); req_ready only in IDLE, response has no backpressure.
module priv_ext_csr_requester #(
  parameter int NUM_EXT        = 2,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                         clk,
  input  logic                         n_rst,
  priv_ext_csr_requester_if.master     bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  state_t            state;
  logic [11:0]       addr_q;
  logic [1:0]        op_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic [31:0]       old_q;
  logic [CNT_W-1:0]  cnt;

  logic              hit;
  logic [31:0]       hit_val;
  logic [31:0]       new_val;

  // Descending scan so the lowest-index responder is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_val = '0;
    for (int i = NUM_EXT - 1; i >= 0; i--) begin
      if (bus.ext_ack[i] && !bus.ext_invalid_csr[i]) begin
        hit     = 1'b1;
        hit_val = bus.ext_value_out[32*i +: 32];
      end
    end
  end

  always_comb begin
    new_val = wdata_q;
    if (op_q == OP_RS)
      new_val = hit_val | wdata_q;
    else if (op_q != OP_RW)
      new_val = hit_val & ~wdata_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state              <= S_IDLE;
      addr_q             <= '0;
      op_q               <= '0;
      wdata_q            <= '0;
      we_q               <= 1'b0;
      old_q              <= '0;
      cnt                <= '0;
      bus.req_ready      <= 1'b1;
      bus.resp_valid     <= 1'b0;
      bus.resp_rdata     <= '0;
      bus.resp_invalid   <= 1'b0;
      bus.ext_csr_addr   <= '0;
      bus.ext_csr_active <= 1'b0;
      bus.ext_value_in   <= '0;
    end else begin
      bus.resp_valid     <= 1'b0;
      bus.ext_csr_active <= 1'b0;
      bus.ext_value_in   <= '0;
      case (state)
        S_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            addr_q        <= bus.req_addr;
            op_q          <= bus.req_op;
            wdata_q       <= bus.req_wdata;
            we_q          <= bus.req_write_en;
            bus.req_ready <= 1'b0;
            if (bus.req_op == 2'b00) begin
              state            <= S_RESP;
              bus.resp_valid   <= 1'b1;
              bus.resp_invalid <= 1'b1;
              bus.resp_rdata   <= '0;
            end else begin
              state            <= S_READ;
              cnt              <= '0;
              bus.ext_csr_addr <= bus.req_addr;
            end
          end
        end
        S_READ: begin
          if (hit) begin
            if (we_q && addr_q[11:10] == 2'b11) begin
              state            <= S_RESP;
              bus.resp_valid   <= 1'b1;
              bus.resp_invalid <= 1'b1;
              bus.resp_rdata   <= '0;
            end else if (we_q) begin
              // resp_rdata must hold the previous response until RESP, so park the old value.
              state              <= S_WRITE;
              old_q              <= hit_val;
              bus.ext_csr_active <= 1'b1;
              bus.ext_value_in   <= new_val;
            end else begin
              state            <= S_RESP;
              bus.resp_valid   <= 1'b1;
              bus.resp_invalid <= 1'b0;
              bus.resp_rdata   <= hit_val;
            end
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state            <= S_RESP;
            bus.resp_valid   <= 1'b1;
            bus.resp_invalid <= 1'b1;
            bus.resp_rdata   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WRITE: begin
          state            <= S_RESP;
          bus.resp_valid   <= 1'b1;
          bus.resp_invalid <= 1'b0;
          bus.resp_rdata   <= old_q;
        end
        S_RESP: begin
          state         <= S_IDLE;
          bus.req_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_priv_ext_csr_requester.sv
// Bench for priv_ext_csr_requester: directed scenarios plus randomized accesses against a behavioural model.
module tb_priv_ext_csr_requester;
  localparam int NE  = 2;
  localparam int TMO = 8;

  logic clk;
  logic n_rst;
  int   n_checks;
  int   n_fails;

  logic [NE-1:0]    cfg_ack;
  logic [NE-1:0]    cfg_inv;
  logic [32*NE-1:0] cfg_val;
  int               cfg_delay;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic        invalid;
    int          n_strobe;
    logic [31:0] strobe_val;
    logic [11:0] strobe_addr;
    logic        stray;
    int          wait_cyc;
    logic        timed_out;
  } obs_t;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic        invalid;
    logic        wr;
    logic [31:0] wval;
  } exp_t;

  priv_ext_csr_requester_if #(.NUM_EXT(NE)) bus ();

  priv_ext_csr_requester #(.NUM_EXT(NE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_ext(input logic [NE-1:0] ack, input logic [NE-1:0] inv,
                         input logic [31:0] v0, input logic [31:0] v1, input int d);
    cfg_ack = ack; cfg_inv = inv; cfg_val = {v1, v0}; cfg_delay = d;
  endtask

  // Expected outcome from the access rules: responder choice, timeout, read-only space, RMW op.
  function automatic exp_t model(input logic [11:0] a, input logic [1:0] op,
                                 input logic [31:0] w, input logic we);
    exp_t e;
    int win;
    logic [31:0] old;
    e.lat = 0; e.rdata = '0; e.invalid = 1'b1; e.wr = 1'b0; e.wval = '0;
    win = -1;
    for (int i = 0; i < NE; i++)
      if (win < 0 && cfg_ack[i] && !cfg_inv[i]) win = i;
    if (op == 2'b00) begin e.lat = 1; return e; end
    if (win < 0 || cfg_delay >= TMO) begin e.lat = TMO + 1; return e; end
    old = cfg_val[win*32 +: 32];
    if (we && a[11:10] == 2'b11) begin e.lat = cfg_delay + 2; return e; end
    e.invalid = 1'b0;
    e.rdata   = old;
    if (we) begin
      e.wr  = 1'b1;
      e.lat = cfg_delay + 3;
      case (op)
        2'b01:   e.wval = w;
        2'b10:   e.wval = old | w;
        default: e.wval = old & ~w;
      endcase
    end else begin
      e.lat = cfg_delay + 2;
    end
    return e;
  endfunction

  // Drives one request, plays the extensions (ack appears from READ cycle cfg_delay on) and records what happened.
  task automatic run_txn(input logic [11:0] a, input logic [1:0] op, input logic [31:0] w,
                         input logic we, output obs_t o);
    bit done;
    o = '{default: 0};
    bus.req_addr = a; bus.req_op = op; bus.req_wdata = w; bus.req_write_en = we;
    bus.req_valid = 1'b1;
    bus.ext_ack = '0; bus.ext_invalid_csr = cfg_inv; bus.ext_value_out = cfg_val;
    while (!bus.req_ready && o.wait_cyc < 50) begin
      @(negedge clk);
      o.wait_cyc++;
    end
    if (!bus.req_ready) begin
      o.timed_out = 1'b1;
      bus.req_valid = 1'b0;
      return;
    end
    done = 1'b0;
    while (!done && o.lat < 60) begin
      @(negedge clk);
      o.lat++;
      bus.req_valid = 1'b0;
      if (bus.ext_csr_active) begin
        o.n_strobe++;
        o.strobe_val  = bus.ext_value_in;
        o.strobe_addr = bus.ext_csr_addr;
      end else if (bus.ext_value_in !== 32'h0) begin
        o.stray = 1'b1;
      end
      if (bus.resp_valid) begin
        done      = 1'b1;
        o.rdata   = bus.resp_rdata;
        o.invalid = bus.resp_invalid;
      end
      bus.ext_ack = (o.lat - 1 >= cfg_delay) ? cfg_ack : '0;
    end
    bus.ext_ack = '0;
    if (!done) o.timed_out = 1'b1;
  endtask

  task automatic test_reset;
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fails++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fails++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
    n_checks++; if (bus.resp_rdata !== 32'h0) begin n_fails++; $display("FAIL reset_resp_rdata got=%h exp=0", bus.resp_rdata); end
    n_checks++; if (bus.resp_invalid !== 1'b0) begin n_fails++; $display("FAIL reset_resp_invalid got=%b exp=0", bus.resp_invalid); end
    n_checks++; if (bus.ext_csr_addr !== 12'h0) begin n_fails++; $display("FAIL reset_ext_addr got=%h exp=0", bus.ext_csr_addr); end
    n_checks++; if (bus.ext_csr_active !== 1'b0) begin n_fails++; $display("FAIL reset_ext_active got=%b exp=0", bus.ext_csr_active); end
    n_checks++; if (bus.ext_value_in !== 32'h0) begin n_fails++; $display("FAIL reset_ext_value_in got=%h exp=0", bus.ext_value_in); end
  endtask

  task automatic test_rw_write;
    obs_t o;
    set_ext(2'b01, 2'b00, 32'hAAAA_0000, 32'h0, 0);
    run_txn(12'h340, 2'b01, 32'h1234, 1'b1, o);
    n_checks++; if (o.n_strobe !== 1) begin n_fails++; $display("FAIL rw_strobes got=%0d exp=1", o.n_strobe); end
    n_checks++; if (o.strobe_val !== 32'h1234) begin n_fails++; $display("FAIL rw_value_in got=%h exp=00001234", o.strobe_val); end
    n_checks++; if (o.strobe_addr !== 12'h340) begin n_fails++; $display("FAIL rw_strobe_addr got=%h exp=340", o.strobe_addr); end
    n_checks++; if (o.rdata !== 32'hAAAA_0000) begin n_fails++; $display("FAIL rw_rdata got=%h exp=aaaa0000", o.rdata); end
    n_checks++; if (o.invalid !== 1'b0) begin n_fails++; $display("FAIL rw_invalid got=%b exp=0", o.invalid); end
    n_checks++; if (o.lat !== 3) begin n_fails++; $display("FAIL rw_latency got=%0d exp=3", o.lat); end
    @(negedge clk);
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fails++; $display("FAIL rw_pulse_width got=%b exp=0", bus.resp_valid); end
    n_checks++; if (bus.resp_rdata !== 32'hAAAA_0000) begin n_fails++; $display("FAIL rw_rdata_hold got=%h exp=aaaa0000", bus.resp_rdata); end
  endtask

  task automatic test_read_only;
    obs_t o;
    set_ext(2'b10, 2'b00, 32'h0, 32'h5, 0);
    run_txn(12'hC81, 2'b10, 32'h0, 1'b0, o);
    n_checks++; if (o.n_strobe !== 0) begin n_fails++; $display("FAIL rs_x0_strobes got=%0d exp=0", o.n_strobe); end
    n_checks++; if (o.rdata !== 32'h5) begin n_fails++; $display("FAIL rs_x0_rdata got=%h exp=5", o.rdata); end
    n_checks++; if (o.lat !== 2) begin n_fails++; $display("FAIL rs_x0_latency got=%0d exp=2", o.lat); end
  endtask

  task automatic test_modify;
    obs_t o;
    set_ext(2'b01, 2'b00, 32'hFF, 32'h0, 0);
    run_txn(12'h300, 2'b11, 32'hF, 1'b1, o);
    n_checks++; if (o.strobe_val !== 32'hF0) begin n_fails++; $display("FAIL rc_value_in got=%h exp=f0", o.strobe_val); end
    n_checks++; if (o.rdata !== 32'hFF) begin n_fails++; $display("FAIL rc_rdata got=%h exp=ff", o.rdata); end
    set_ext(2'b01, 2'b00, 32'h1, 32'h0, 0);
    run_txn(12'h300, 2'b10, 32'h100, 1'b1, o);
    n_checks++; if (o.strobe_val !== 32'h101) begin n_fails++; $display("FAIL rs_value_in got=%h exp=101", o.strobe_val); end
    n_checks++; if (o.n_strobe !== 1) begin n_fails++; $display("FAIL rs_strobes got=%0d exp=1", o.n_strobe); end
  endtask

  task automatic test_ro_space;
    obs_t o;
    set_ext(2'b01, 2'b00, 32'hDEAD_BEEF, 32'h0, 0);
    run_txn(12'hC00, 2'b01, 32'h1234, 1'b1, o);
    n_checks++; if (o.n_strobe !== 0) begin n_fails++; $display("FAIL ro_strobes got=%0d exp=0", o.n_strobe); end
    n_checks++; if (o.invalid !== 1'b1) begin n_fails++; $display("FAIL ro_invalid got=%b exp=1", o.invalid); end
    n_checks++; if (o.rdata !== 32'h0) begin n_fails++; $display("FAIL ro_rdata got=%h exp=0", o.rdata); end
  endtask

  task automatic test_timeout_illegal;
    obs_t o;
    logic [11:0] prev_addr;
    set_ext(2'b11, 2'b11, 32'h77, 32'h88, 0);
    run_txn(12'h123, 2'b01, 32'h9, 1'b0, o);
    n_checks++; if (o.lat !== TMO + 1) begin n_fails++; $display("FAIL timeout_latency got=%0d exp=%0d", o.lat, TMO + 1); end
    n_checks++; if (o.invalid !== 1'b1 || o.rdata !== 32'h0) begin n_fails++; $display("FAIL timeout_resp got=%b/%h exp=1/0", o.invalid, o.rdata); end
    prev_addr = bus.ext_csr_addr;
    set_ext(2'b01, 2'b00, 32'h55, 32'h0, 0);
    run_txn(12'h456, 2'b00, 32'hFFFF, 1'b1, o);
    n_checks++; if (o.lat !== 1) begin n_fails++; $display("FAIL illegal_latency got=%0d exp=1", o.lat); end
    n_checks++; if (o.invalid !== 1'b1 || o.rdata !== 32'h0) begin n_fails++; $display("FAIL illegal_resp got=%b/%h exp=1/0", o.invalid, o.rdata); end
    n_checks++; if (bus.ext_csr_addr !== prev_addr || o.n_strobe !== 0) begin n_fails++; $display("FAIL illegal_bus_idle got addr=%h strobes=%0d exp addr=%h strobes=0", bus.ext_csr_addr, o.n_strobe, prev_addr); end
  endtask

  task automatic test_priority_reset;
    obs_t o;
    bit bad;
    set_ext(2'b11, 2'b00, 32'h11, 32'h22, 0);
    run_txn(12'h300, 2'b10, 32'h0, 1'b0, o);
    n_checks++; if (o.rdata !== 32'h11) begin n_fails++; $display("FAIL priority_rdata got=%h exp=11", o.rdata); end
    @(negedge clk);
    bus.req_addr = 12'h340; bus.req_op = 2'b01; bus.req_wdata = 32'hCAFE; bus.req_write_en = 1'b1;
    bus.req_valid = 1'b1; bus.ext_ack = '0;
    @(negedge clk); bus.req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.ext_csr_addr !== 12'h340) begin n_fails++; $display("FAIL midop_read_addr got=%h exp=340", bus.ext_csr_addr); end
    #2 n_rst = 1'b0;
    #1;
    n_checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.ext_csr_addr !== 12'h0 || bus.ext_csr_active !== 1'b0 || bus.resp_rdata !== 32'h0)
      begin n_fails++; $display("FAIL midop_reset got ready=%b rv=%b addr=%h act=%b rdata=%h exp 1/0/0/0/0", bus.req_ready, bus.resp_valid, bus.ext_csr_addr, bus.ext_csr_active, bus.resp_rdata); end
    bus.ext_ack = 2'b01;
    @(negedge clk); n_rst = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.ext_csr_active || bus.resp_valid || !bus.req_ready) bad = 1'b1;
    end
    bus.ext_ack = '0;
    n_checks++; if (bad !== 1'b0) begin n_fails++; $display("FAIL midop_after_reset got activity=%b exp=0", bad); end
  endtask

  task automatic test_back_to_back;
    obs_t o;
    exp_t e;
    logic [31:0] vals [3];
    vals[0] = 32'h1; vals[1] = 32'h2; vals[2] = 32'h3;
    for (int k = 0; k < 3; k++) begin
      set_ext(2'b01, 2'b00, vals[k], 32'h0, 0);
      e = model(12'h300, 2'b10, 32'h10, k[0]);
      run_txn(12'h300, 2'b10, 32'h10, k[0], o);
      n_checks++; if (o.rdata !== e.rdata || o.lat !== e.lat) begin n_fails++; $display("FAIL b2b_%0d got rdata=%h lat=%0d exp rdata=%h lat=%0d", k, o.rdata, o.lat, e.rdata, e.lat); end
      if (k > 0) begin
        n_checks++; if (o.wait_cyc !== 1) begin n_fails++; $display("FAIL b2b_ready_gap_%0d got=%0d exp=1", k, o.wait_cyc); end
      end
    end
  endtask

  task automatic test_random;
    obs_t o;
    exp_t e;
    logic [11:0] a;
    logic [1:0]  op;
    logic [31:0] w;
    logic        we;
    for (int n = 0; n < 60; n++) begin
      set_ext(2'($urandom), 2'($urandom_range(0, 3) == 0 ? 2'($urandom) : 2'b00), $urandom, $urandom, int'($urandom_range(0, 9)));
      a  = 12'($urandom);
      op = 2'($urandom);
      w  = $urandom;
      we = 1'($urandom);
      e = model(a, op, w, we);
      run_txn(a, op, w, we, o);
      n_checks++; if (o.timed_out !== 1'b0 || o.lat !== e.lat) begin n_fails++; $display("FAIL rnd%0d_latency got=%0d(to=%b) exp=%0d", n, o.lat, o.timed_out, e.lat); end
      n_checks++; if (o.rdata !== e.rdata || o.invalid !== e.invalid) begin n_fails++; $display("FAIL rnd%0d_resp got=%h/%b exp=%h/%b", n, o.rdata, o.invalid, e.rdata, e.invalid); end
      n_checks++; if (o.n_strobe !== int'(e.wr) || o.stray !== 1'b0) begin n_fails++; $display("FAIL rnd%0d_strobes got=%0d stray=%b exp=%0d", n, o.n_strobe, o.stray, e.wr); end
      if (e.wr) begin
        n_checks++; if (o.strobe_val !== e.wval || o.strobe_addr !== a) begin n_fails++; $display("FAIL rnd%0d_write got=%h@%h exp=%h@%h", n, o.strobe_val, o.strobe_addr, e.wval, a); end
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0; n_fails = 0;
    n_rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_op = '0; bus.req_wdata = '0; bus.req_write_en = 1'b0;
    bus.ext_ack = '0; bus.ext_invalid_csr = '0; bus.ext_value_out = '0;
    set_ext(2'b00, 2'b00, 32'h0, 32'h0, 0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    test_reset;
    test_rw_write;
    test_read_only;
    test_modify;
    test_ro_space;
    test_timeout_illegal;
    test_priority_reset;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
